// File: rtl/param_shift_unit_if.sv
// Handshake and data bundle between the operand/result registers and the shift unit.
// The requester drives the master modport; the unit itself uses the slave modport.
interface param_shift_unit_if #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
);
  logic               start;
  logic [1:0]         mode;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   cct_input;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   cct_output;

  modport master (
    output start, mode, shamt, cct_input,
    input  busy, done, cct_output
  );

  modport slave (
    input  start, mode, shamt, cct_input,
    output busy, done, cct_output
  );
endinterface

// File: rtl/param_shift_unit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, done pulse on result update.
// Modes: 00 ASR, 01 LSR, 10 LSL, 11 ROR.
module param_shift_unit #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
  input  logic                clk,
  input  logic                clear,
  param_shift_unit_if.slave   bus
);

  localparam logic [1:0] MODE_ASR = 2'b00;
  localparam logic [1:0] MODE_LSR = 2'b01;
  localparam logic [1:0] MODE_LSL = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_FINISH = 2'b10
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   w_q, w_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         mode_q, mode_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   out_q, out_d;

  function automatic logic [WIDTH-1:0] step_f(input logic [WIDTH-1:0] w, input logic [1:0] m);
    logic [WIDTH-1:0] r;
    case (m)
      MODE_ASR: r = {w[WIDTH-1], w[WIDTH-1:1]};
      MODE_LSR: r = {1'b0, w[WIDTH-1:1]};
      MODE_LSL: r = {w[WIDTH-2:0], 1'b0};
      MODE_ROR: r = {w[0], w[WIDTH-1:1]};
      default:  r = w;
    endcase
    return r;
  endfunction

  // Next-state and datapath control; FINISH publishes the result and may accept a new op.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    out_d   = out_q;
    case (state_q)
      ST_SHIFT: begin
        w_d   = step_f(w_q, mode_q);
        cnt_d = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_SHIFT;
          busy_d  = 1'b1;
        end
      end
      ST_IDLE, ST_FINISH: begin
        if (state_q == ST_FINISH) begin
          done_d = 1'b1;
          out_d  = w_q;
        end else begin
          done_d = 1'b0;
        end
        if (bus.start) begin
          w_d    = bus.cct_input;
          mode_d = bus.mode;
          cnt_d  = bus.shamt;
          if (bus.shamt != '0) begin
            state_d = ST_SHIFT;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_FINISH;
            busy_d  = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation without a done pulse.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      cnt_q   <= '0;
      mode_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.cct_output = out_q;

endmodule

// File: tb/tb_param_shift_unit.sv
// Directed bench for param_shift_unit: an 8-bit instance driven from a vector table
// plus corner sequences, and a 16-bit instance for long/overflowing shift amounts.
module tb_param_shift_unit;

  logic clk = 1'b0;
  logic clear = 1'b0;
  always #5 clk = ~clk;

  param_shift_unit_if #(.WIDTH(8),  .SHAMT_W(3)) a8 ();
  param_shift_unit_if #(.WIDTH(16), .SHAMT_W(5)) a16 ();

  param_shift_unit #(.WIDTH(8),  .SHAMT_W(3)) dut8  (.clk(clk), .clear(clear), .bus(a8.slave));
  param_shift_unit #(.WIDTH(16), .SHAMT_W(5)) dut16 (.clk(clk), .clear(clear), .bus(a16.slave));

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else pass_cnt++;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [2:0] shamt;
    logic [7:0] din;
    logic [7:0] exp;
  } vec8_t;

  typedef struct {
    logic [1:0]  mode;
    logic [4:0]  shamt;
    logic [15:0] din;
    logic [15:0] exp;
  } vec16_t;

  task automatic run8(input vec8_t v, input string nm);
    int lat;
    @(negedge clk);
    a8.start = 1'b1; a8.mode = v.mode; a8.shamt = v.shamt; a8.cct_input = v.din;
    @(posedge clk); #1;
    a8.start = 1'b0; a8.mode = ~v.mode; a8.shamt = ~v.shamt; a8.cct_input = ~v.din;
    lat = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (a8.done) lat = c;
    end
    chk({nm, " latency"}, 32'(lat), 32'(v.shamt) + 32'd1);
    chk({nm, " result"}, 32'(a8.cct_output), 32'(v.exp));
    @(posedge clk); #1;
    chk({nm, " done pulse"}, 32'(a8.done), 32'd0);
  endtask

  task automatic run16(input vec16_t v, input string nm);
    int lat;
    @(negedge clk);
    a16.start = 1'b1; a16.mode = v.mode; a16.shamt = v.shamt; a16.cct_input = v.din;
    @(posedge clk); #1;
    a16.start = 1'b0; a16.mode = ~v.mode; a16.shamt = ~v.shamt; a16.cct_input = ~v.din;
    lat = 0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (a16.done) lat = c;
    end
    chk({nm, " latency"}, 32'(lat), 32'(v.shamt) + 32'd1);
    chk({nm, " result"}, 32'(a16.cct_output), 32'(v.exp));
  endtask

  vec8_t  vecs8[9];
  vec16_t vecs16[4];

  initial begin
    int n_done;
    int first_cyc;
    int second_cyc;
    logic [7:0] first_val;
    logic [7:0] second_val;

    vecs8[0] = '{2'b00, 3'd2, 8'h96, 8'hE5};
    vecs8[1] = '{2'b01, 3'd2, 8'h96, 8'h25};
    vecs8[2] = '{2'b10, 3'd3, 8'h96, 8'hB0};
    vecs8[3] = '{2'b11, 3'd1, 8'h96, 8'h4B};
    vecs8[4] = '{2'b00, 3'd0, 8'h5A, 8'h5A};
    vecs8[5] = '{2'b00, 3'd7, 8'h80, 8'hFF};
    vecs8[6] = '{2'b01, 3'd7, 8'hFF, 8'h01};
    vecs8[7] = '{2'b11, 3'd7, 8'h96, 8'h2D};
    vecs8[8] = '{2'b10, 3'd7, 8'h01, 8'h80};

    vecs16[0] = '{2'b11, 5'd17, 16'h8001, 16'hC000};
    vecs16[1] = '{2'b10, 5'd20, 16'hFFFF, 16'h0000};
    vecs16[2] = '{2'b00, 5'd31, 16'h8000, 16'hFFFF};
    vecs16[3] = '{2'b11, 5'd16, 16'h1234, 16'h1234};

    a8.start = 1'b0;  a8.mode = 2'b00;  a8.shamt = 3'd0;  a8.cct_input = 8'h00;
    a16.start = 1'b0; a16.mode = 2'b00; a16.shamt = 5'd0; a16.cct_input = 16'h0000;

    // Reset state
    #12;
    chk("rst busy8", 32'(a8.busy), 32'd0);
    chk("rst done8", 32'(a8.done), 32'd0);
    chk("rst out8", 32'(a8.cct_output), 32'd0);
    chk("rst busy16", 32'(a16.busy), 32'd0);
    chk("rst out16", 32'(a16.cct_output), 32'd0);
    @(negedge clk);
    clear = 1'b1;

    for (int i = 0; i < 9; i++) run8(vecs8[i], $sformatf("vec8[%0d]", i));
    for (int i = 0; i < 4; i++) run16(vecs16[i], $sformatf("vec16[%0d]", i));

    // Start pulses while busy must be ignored
    @(negedge clk);
    a8.start = 1'b1; a8.mode = 2'b00; a8.shamt = 3'd5; a8.cct_input = 8'h96;
    @(posedge clk); #1;
    a8.start = 1'b0;
    n_done = 0; first_cyc = 0; first_val = 8'h00;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("busy during shift", 32'(a8.busy), 32'd1);
      if (a8.done) begin
        n_done++;
        if (first_cyc == 0) begin first_cyc = c; first_val = a8.cct_output; end
      end
      a8.start = (c == 2 || c == 4) ? 1'b1 : 1'b0;
      a8.mode = 2'b10; a8.shamt = 3'd1; a8.cct_input = 8'h01;
    end
    a8.start = 1'b0;
    chk("ignore start done count", 32'(n_done), 32'd1);
    chk("ignore start done cycle", 32'(first_cyc), 32'd6);
    chk("ignore start result", 32'(first_val), 32'hFC);

    // Back-to-back: start held high is accepted again in FINISH
    @(negedge clk);
    a8.start = 1'b1; a8.mode = 2'b00; a8.shamt = 3'd2; a8.cct_input = 8'h96;
    @(posedge clk); #1;
    a8.mode = 2'b01;
    first_cyc = 0; second_cyc = 0; first_val = 8'h00; second_val = 8'h00;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 3) a8.start = 1'b0;
      if (a8.done) begin
        if (first_cyc == 0) begin first_cyc = c; first_val = a8.cct_output; end
        else if (second_cyc == 0) begin second_cyc = c; second_val = a8.cct_output; end
      end
    end
    chk("b2b first cycle", 32'(first_cyc), 32'd3);
    chk("b2b first result", 32'(first_val), 32'hE5);
    chk("b2b second cycle", 32'(second_cyc), 32'd6);
    chk("b2b second result", 32'(second_val), 32'h25);

    // Reset mid-shift aborts without a done pulse
    @(negedge clk);
    a8.start = 1'b1; a8.mode = 2'b00; a8.shamt = 3'd5; a8.cct_input = 8'h96;
    @(posedge clk); #1;
    a8.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-abort busy", 32'(a8.busy), 32'd1);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("abort out", 32'(a8.cct_output), 32'd0);
    chk("abort busy", 32'(a8.busy), 32'd0);
    chk("abort done", 32'(a8.done), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (a8.done) n_done++;
    end
    chk("abort no done", 32'(n_done), 32'd0);
    run8(vecs8[3], "after abort");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
